mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be MEM_SIZE_BYTES=4096 (power of 2), DATA_WIDTH_BYTES=4, ADDR_WIDTH=$clog2(MEM_SIZE_BYTES).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock, all state on posedge.
- rst_bar  in  1  synchronous active-low reset.
- ld_valid  in  1  loader word offered.
- ld_data  in  32  loader word, byte 0 = bits 7:0.
- ld_last  in  1  final loader word.
- ld_ready  out  1  loader word accepted this cycle.
- ld_done  out  1  load phase finished.
- if_req  in  1  instruction-fetch read request.
- if_addr  in  ADDR_WIDTH  fetch byte address.
- if_gnt  out  1  fetch granted this cycle.
- if_rvalid  out  1  fetch data on rdata.
- d_req  in  1  data-port request.
- d_we  in  1  1 = write.
- d_be  in  4  active-high byte enables.
- d_addr  in  ADDR_WIDTH  data byte address.
- d_wdata  in  32  write data.
- d_gnt  out  1  data granted this cycle.
- d_rvalid  out  1  data read result on rdata.
- rdata  out  32  shared read data.
- mem_addr  out  ADDR_WIDTH  memory word address.
- mem_data_w  out  32  memory write data.
- mem_w_bar  out  4  active-low per-byte memory write strobes.
- mem_data_r  in  32  memory read data, valid the cycle after address presented.

Function
REQ-003 The FSM SHALL have states LOAD and RUN; after reset it SHALL be in LOAD.
REQ-004 In LOAD, ld_ready SHALL be 1, if_gnt=d_gnt=0, and ld_valid=1 SHALL write ld_data to the load pointer with mem_w_bar=4'b0000.
REQ-005 The load pointer SHALL start at 0 and advance by 4 per accepted word.
REQ-006 LOAD->RUN SHALL occur on the edge accepting ld_last=1, or accepting the word at MEM_SIZE_BYTES-4 (no wrap).
REQ-007 On that edge, ld_done SHALL rise and stay 1 until reset.
REQ-008 In RUN, ld_ready SHALL be 0.
REQ-009 In RUN, at most one of if_gnt/d_gnt SHALL be 1 per cycle.
REQ-010 Grants SHALL be combinational from requests in the same cycle.
REQ-011 Single request: it is granted; both: round-robin, granting the port not granted most recently; the priority pointer SHALL reset to favour d.
REQ-012 Requesters SHALL hold req and address/data stable until gnt; the block SHALL NOT queue requests.
REQ-013 mem_addr SHALL be the granted address with bits 1:0 forced to 0; unaligned low bits ignored.
REQ-014 A granted d write SHALL drive mem_w_bar=~d_be; d_be=0 SHALL be granted with no byte written.
REQ-015 All other cycles SHALL drive mem_w_bar=4'b1111.
REQ-016 A granted read SHALL raise the matching *_rvalid exactly one cycle later, with rdata=mem_data_r; writes SHALL produce no rvalid.
REQ-017 Back-to-back grants every cycle SHALL be supported (one read per cycle, throughput 1).
REQ-018 A write followed next cycle by a read of the same word SHALL return the new data.

Reset
REQ-019 With rst_bar=0 at posedge, the block SHALL enter LOAD with load pointer=0, ld_done=0, if_rvalid=d_rvalid=0, rdata=0, and the priority pointer favouring d.
REQ-020 A reset arriving one cycle after a read grant SHALL suppress that rvalid.
REQ-021 During reset, mem_w_bar SHALL be 4'b1111 and all grants 0.
REQ-022 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-023 MEM_SIZE_BYTES, DATA_WIDTH_BYTES, ADDR_WIDTH and the state enum {LOAD, RUN} SHALL live in a shared package, mem_pkg.
REQ-024 The arbitration decision SHALL be a sub-module, rr_arb2 (2-way round-robin, pointer register inside).
REQ-025 The block SHALL contain no memory storage; it connects to the existing mem module.

Verification
REQ-026 Load 3 words 0x11223344, 0x55667788, 0xA5A5A5A5 (last on third) -> writes to addresses 0, 4, 8; ld_done=1 after the third edge; later if reads return these words.
REQ-027 Load 1024 words, none with ld_last -> RUN entered after word at 0xFFC; the 1025th ld_valid not accepted.
REQ-028 RUN, if_req and d_req held 1 for 4 cycles -> grants d,if,d,if; each rvalid one cycle after its grant.
REQ-029 d write 0xDEADBEEF, d_be=4'b0101, to 0x010 over 0x00000000 -> reading 0x010 next cycle yields 0x00AD00EF.
REQ-030 if read 0x013 -> mem_addr=0x010.
REQ-031 Reset asserted the cycle after a d read grant -> d_rvalid stays 0, FSM in LOAD, ld_done=0.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_pkg : shared memory geometry and arbiter state encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
package mem_pkg;
  localparam int MEM_SIZE_BYTES   = 4096;
  localparam int DATA_WIDTH_BYTES = 4;
  localparam int ADDR_WIDTH       = $clog2(MEM_SIZE_BYTES);

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } arb_state_t;
endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arb2 : two-way round-robin arbiter; pointer resets to favour the d port
// Revision: 1.0
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic clk,
  input  logic rst_bar,
  input  logic req_d,
  input  logic req_if,
  output logic gnt_d,
  output logic gnt_if
);
  logic r_favour_d;

  assign gnt_d  = req_d  && (!req_if || r_favour_d);
  assign gnt_if = req_if && (!req_d  || !r_favour_d);

  // Any grant hands priority to the other port, so a lone request also counts.
  always_ff @(posedge clk) begin
    if (!rst_bar) begin
      r_favour_d <= 1'b1;
    end else if (gnt_d) begin
      r_favour_d <= 1'b0;
    end else if (gnt_if) begin
      r_favour_d <= 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter : boot loader then fetch/data round-robin access to one memory
// Revision: 1.0
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_bar,
  input  logic                          ld_valid,
  input  logic [8*DATA_WIDTH_BYTES-1:0] ld_data,
  input  logic                          ld_last,
  output logic                          ld_ready,
  output logic                          ld_done,
  input  logic                          if_req,
  input  logic [ADDR_WIDTH-1:0]         if_addr,
  output logic                          if_gnt,
  output logic                          if_rvalid,
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [DATA_WIDTH_BYTES-1:0]   d_be,
  input  logic [ADDR_WIDTH-1:0]         d_addr,
  input  logic [8*DATA_WIDTH_BYTES-1:0] d_wdata,
  output logic                          d_gnt,
  output logic                          d_rvalid,
  output logic [8*DATA_WIDTH_BYTES-1:0] rdata,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [8*DATA_WIDTH_BYTES-1:0] mem_data_w,
  output logic [DATA_WIDTH_BYTES-1:0]   mem_w_bar,
  input  logic [8*DATA_WIDTH_BYTES-1:0] mem_data_r
);
  localparam logic [ADDR_WIDTH-1:0] c_WORD_STEP  = ADDR_WIDTH'(DATA_WIDTH_BYTES);
  localparam logic [ADDR_WIDTH-1:0] c_LAST_WORD  = ADDR_WIDTH'(MEM_SIZE_BYTES - DATA_WIDTH_BYTES);
  localparam logic [ADDR_WIDTH-1:0] c_ALIGN_MASK = ~ADDR_WIDTH'(DATA_WIDTH_BYTES - 1);

  arb_state_t            r_state;
  arb_state_t            w_state_next;
  logic [ADDR_WIDTH-1:0] r_ld_ptr;
  logic                  r_ld_done;
  logic                  r_if_rvalid;
  logic                  r_d_rvalid;
  logic                  w_run;
  logic                  w_ld_accept;
  logic                  w_ld_final;
  logic                  w_gnt_if;
  logic                  w_gnt_d;
  logic [ADDR_WIDTH-1:0] w_sel_addr;

  assign w_run       = rst_bar && (r_state == RUN);
  assign w_ld_accept = rst_bar && (r_state == LOAD) && ld_valid;
  assign w_ld_final  = ld_last || (r_ld_ptr == c_LAST_WORD);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_bar (rst_bar),
    .req_d   (w_run && d_req),
    .req_if  (w_run && if_req),
    .gnt_d   (w_gnt_d),
    .gnt_if  (w_gnt_if)
  );

  always_ff @(posedge clk) begin
    if (!rst_bar) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    ld_ready     = 1'b0;
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;
    w_sel_addr   = r_ld_ptr;
    mem_data_w   = ld_data;
    mem_w_bar    = '1;
    if (rst_bar) begin
      case (r_state)
        LOAD: begin
          ld_ready = 1'b1;
          if (ld_valid) begin
            mem_w_bar = '0;
            if (w_ld_final) begin
              w_state_next = RUN;
            end
          end
        end
        RUN: begin
          if_gnt     = w_gnt_if;
          d_gnt      = w_gnt_d;
          mem_data_w = d_wdata;
          w_sel_addr = w_gnt_if ? if_addr : d_addr;
          if (w_gnt_d && d_we) begin
            mem_w_bar = ~d_be;
          end
        end
        default: w_state_next = LOAD;
      endcase
    end
  end

  assign mem_addr = w_sel_addr & c_ALIGN_MASK;

  always_ff @(posedge clk) begin
    if (!rst_bar) begin
      r_ld_ptr    <= '0;
      r_ld_done   <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
    end else begin
      if (w_ld_accept) begin
        r_ld_ptr <= r_ld_ptr + c_WORD_STEP;
        if (w_ld_final) begin
          r_ld_done <= 1'b1;
        end
      end
      r_if_rvalid <= w_gnt_if;
      r_d_rvalid  <= w_gnt_d && !d_we;
    end
  end

  // Gating by rst_bar kills a read response whose cycle coincides with reset.
  assign ld_done   = r_ld_done;
  assign if_rvalid = r_if_rvalid && rst_bar;
  assign d_rvalid  = r_d_rvalid && rst_bar;
  assign rdata     = (if_rvalid || d_rvalid) ? mem_data_r : '0;
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_arbiter : random + directed bench with a word-level reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int AW    = ADDR_WIDTH;
  localparam int WORDS = MEM_SIZE_BYTES / 4;

  logic          clk = 1'b0;
  logic          rst_bar;
  logic          ld_valid, ld_last, ld_ready, ld_done;
  logic [31:0]   ld_data;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata, rdata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data_w, mem_data_r;
  logic [3:0]    mem_w_bar;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_bar(rst_bar),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_done(ld_done),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .rdata(rdata),
    .mem_addr(mem_addr), .mem_data_w(mem_data_w), .mem_w_bar(mem_w_bar),
    .mem_data_r(mem_data_r)
  );

  // Stand-in for the external synchronous memory, driven only by DUT pins.
  logic [31:0] env_mem [WORDS];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (!mem_w_bar[b]) env_mem[int'(mem_addr) / 4][8*b +: 8] <= mem_data_w[8*b +: 8];
    mem_data_r <= env_mem[int'(mem_addr) / 4];
  end

  // Reference model state: word array, load progress, who was granted last.
  logic [31:0] model_mem [WORDS];
  bit          m_run = 0, m_done = 0, m_favour_d = 1;
  int          m_ptr = 0;
  bit          m_pend_if = 0, m_pend_d = 0;
  logic [31:0] m_pend_data = '0;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      env_mem[i]   = '0;
      model_mem[i] = '0;
    end
  end

  always @(negedge clk) begin : p_cmp
    bit          e_gnt_if, e_gnt_d, nx_if, nx_d;
    logic [3:0]  e_wbar;
    logic [31:0] nx_data;
    int          w;
    e_gnt_if = 0; e_gnt_d = 0; nx_if = 0; nx_d = 0; e_wbar = 4'hF; nx_data = '0;
    check("if_rvalid", 32'(if_rvalid), 32'(rst_bar && m_pend_if));
    check("d_rvalid", 32'(d_rvalid), 32'(rst_bar && m_pend_d));
    if (rst_bar && (m_pend_if || m_pend_d)) check("rdata", rdata, m_pend_data);
    check("ld_done", 32'(ld_done), 32'(m_done));
    check("ld_ready", 32'(ld_ready), 32'(rst_bar && !m_run));
    if (!rst_bar) begin
      m_run = 0; m_ptr = 0; m_done = 0; m_favour_d = 1;
    end else if (!m_run) begin
      if (ld_valid) begin
        e_wbar = 4'h0;
        check("ld_addr", 32'(mem_addr), 32'(m_ptr));
        check("ld_wdata", mem_data_w, ld_data);
        model_mem[m_ptr / 4] = ld_data;
        if (ld_last || m_ptr == MEM_SIZE_BYTES - 4) begin
          m_run = 1; m_done = 1;
        end
        m_ptr += 4;
      end
    end else begin
      if (d_req && if_req) begin
        e_gnt_d  = m_favour_d;
        e_gnt_if = !m_favour_d;
      end else begin
        e_gnt_d  = d_req;
        e_gnt_if = if_req;
      end
      if (e_gnt_d) begin
        m_favour_d = 0;
        w = int'(d_addr) / 4;
        check("d_mem_addr", 32'(mem_addr), 32'(w * 4));
        if (d_we) begin
          e_wbar = ~d_be;
          check("d_mem_wdata", mem_data_w, d_wdata);
          for (int b = 0; b < 4; b++)
            if (d_be[b]) model_mem[w][8*b +: 8] = d_wdata[8*b +: 8];
        end else begin
          nx_d = 1; nx_data = model_mem[w];
        end
      end else if (e_gnt_if) begin
        m_favour_d = 1;
        w = int'(if_addr) / 4;
        check("if_mem_addr", 32'(mem_addr), 32'(w * 4));
        nx_if = 1; nx_data = model_mem[w];
      end
    end
    check("if_gnt", 32'(if_gnt), 32'(e_gnt_if));
    check("d_gnt", 32'(d_gnt), 32'(e_gnt_d));
    check("mem_w_bar", 32'(mem_w_bar), 32'(e_wbar));
    m_pend_if = nx_if; m_pend_d = nx_d; m_pend_data = nx_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ld_valid = 0; ld_last = 0; if_req = 0; d_req = 0; d_we = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : p_stim
    logic [31:0] words [3];
    bit          hold_if, hold_d;
    words[0] = 32'h11223344; words[1] = 32'h55667788; words[2] = 32'hA5A5A5A5;
    rst_bar = 0; idle();
    ld_data = '0; if_addr = '0; d_addr = '0; d_be = '0; d_wdata = '0;
    tick(); tick();
    rst_bar = 1;
    @(negedge clk);
    check("rst_ld_ready", 32'(ld_ready), 32'd1);
    check("rst_ld_done", 32'(ld_done), 32'd0);
    check("rst_rvalid", 32'(if_rvalid | d_rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_wbar", 32'(mem_w_bar), 32'hF);

    // Three-word load ending with ld_last
    for (int i = 0; i < 3; i++) begin
      tick();
      ld_valid = 1; ld_data = words[i]; ld_last = (i == 2);
      @(negedge clk);
      check("load3_addr", 32'(mem_addr), 32'(i * 4));
      check("load3_wbar", 32'(mem_w_bar), 32'h0);
    end
    tick(); idle();
    @(negedge clk);
    check("load3_done", 32'(ld_done), 32'd1);
    check("load3_ready_off", 32'(ld_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); if_req = 1; if_addr = AW'(i * 4);
      @(negedge clk);
      check("fetch_gnt", 32'(if_gnt), 32'd1);
      tick(); idle();
      @(negedge clk);
      check("fetch_rvalid", 32'(if_rvalid), 32'd1);
      check("fetch_rdata", rdata, words[i]);
    end

    // Both ports requesting continuously alternate starting with d
    tick(); if_req = 1; d_req = 1; d_we = 0; if_addr = AW'(8); d_addr = AW'(4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rr_d_gnt", 32'(d_gnt), 32'(k % 2 == 0));
      check("rr_if_gnt", 32'(if_gnt), 32'(k % 2 == 1));
      if (k > 0) check("rr_d_rvalid", 32'(d_rvalid), 32'(k % 2 == 1));
      tick();
    end
    idle();
    @(negedge clk);
    check("rr_last_rvalid", 32'(if_rvalid), 32'd1);

    // Byte-enabled write then immediate read of the same word
    tick(); d_req = 1; d_we = 1; d_be = 4'hF; d_addr = AW'(12'h010); d_wdata = 32'h0;
    tick(); d_be = 4'b0101; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("be_wbar", 32'(mem_w_bar), 32'hA);
    tick(); d_we = 0;
    tick(); idle();
    @(negedge clk);
    check("be_rdata", rdata, 32'h00AD00EF);
    check("be_model_pin", model_mem[4], 32'h00AD00EF);

    tick(); if_req = 1; if_addr = AW'(12'h013);
    @(negedge clk);
    check("unaligned_addr", 32'(mem_addr), 32'h010);
    tick(); idle();
    @(negedge clk);
    check("unaligned_rdata", rdata, 32'h00AD00EF);

    // Zero byte-enable write is granted but leaves memory untouched
    tick(); d_req = 1; d_we = 1; d_be = 4'h0; d_addr = AW'(12'h010); d_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("be0_gnt", 32'(d_gnt), 32'd1);
    check("be0_wbar", 32'(mem_w_bar), 32'hF);
    tick(); d_we = 0;
    tick(); idle();
    @(negedge clk);
    check("be0_rdata", rdata, 32'h00AD00EF);

    // Random traffic; an ungranted requester holds its request unchanged
    hold_if = 0; hold_d = 0;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (!hold_if) begin
        if_req  = ($urandom % 2) == 1;
        if_addr = AW'($urandom_range(0, 63));
      end
      if (!hold_d) begin
        d_req   = ($urandom % 3) != 0;
        d_we    = ($urandom % 2) == 1;
        d_be    = 4'($urandom);
        d_addr  = AW'($urandom_range(0, 63));
        d_wdata = $urandom;
      end
      @(negedge clk);
      hold_if = if_req && !if_gnt;
      hold_d  = d_req && !d_gnt;
    end
    tick(); idle();

    // Reset the cycle after a read grant
    tick(); d_req = 1; d_we = 0; d_addr = AW'(8);
    @(negedge clk);
    check("rstrd_gnt", 32'(d_gnt), 32'd1);
    tick(); idle(); rst_bar = 0;
    @(negedge clk);
    check("rstrd_rvalid", 32'(d_rvalid), 32'd0);
    tick();
    @(negedge clk);
    check("rstrd_done", 32'(ld_done), 32'd0);
    rst_bar = 1;
    @(negedge clk);
    check("rstrd_load", 32'(ld_ready), 32'd1);

    // Full-memory load without ld_last
    for (int i = 0; i < WORDS; i++) begin
      tick(); ld_valid = 1; ld_last = 0; ld_data = $urandom;
      if (i == 0 || i == WORDS - 1) begin
        @(negedge clk);
        check("full_addr", 32'(mem_addr), 32'(i * 4));
      end
    end
    tick(); ld_valid = 1; ld_data = 32'hCAFEF00D;
    @(negedge clk);
    check("full_extra_ready", 32'(ld_ready), 32'd0);
    check("full_extra_wbar", 32'(mem_w_bar), 32'hF);
    check("full_done", 32'(ld_done), 32'd1);

    for (int c = 0; c < 60; c++) begin
      tick(); idle();
      if_req = ($urandom % 2) == 1; if_addr = AW'($urandom);
      d_req  = ($urandom % 2) == 1; d_addr  = AW'($urandom); d_we = 0;
    end
    tick(); idle();
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
